// File: rtl/phase_seq_pkg.sv
// Shared constants for the instruction phase sequencer: phase count, phase
// indices and the default MEM-phase stall limit.
package phase_seq_pkg;
    localparam int PHASES          = 5;
    localparam int MEM_TIMEOUT_DEF = 15;

    localparam logic [2:0] FETCH = 3'd0;
    localparam logic [2:0] REG   = 3'd1;
    localparam logic [2:0] EXEC  = 3'd2;
    localparam logic [2:0] MEM   = 3'd3;
    localparam logic [2:0] WB    = 3'd4;
endpackage

// File: rtl/phase_ctr.sv
// Modulo-N phase counter; holds its value while i_hold is set.
module phase_ctr #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_hold,
    output logic [W-1:0] o_phase
);
    logic [W-1:0] r_phase;

    always_ff @(posedge clk) begin
        if (reset)
            r_phase <= '0;
        else if (!i_hold)
            r_phase <= (r_phase == W'(N - 1)) ? '0 : r_phase + 1'b1;
    end

    assign o_phase = r_phase;
endmodule

// File: rtl/phase_seq.sv
// Instruction phase sequencer: steps FETCH..WB, stretches MEM for slow memory
// with a bounded timeout, and supports debugger halt / single-step.
module phase_seq #(
    parameter int PHASES      = phase_seq_pkg::PHASES,
    parameter int MEM_TIMEOUT = phase_seq_pkg::MEM_TIMEOUT_DEF,
    parameter int CNTW        = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        halt_req,
    input  logic                        step_req,
    input  logic                        mem_access,
    input  logic                        mem_ready,
    output logic [$clog2(PHASES)-1:0]   phase,
    output logic [PHASES-1:0]           phase_en,
    output logic                        mem_we_en,
    output logic                        wb_en,
    output logic                        halted,
    output logic                        mem_err,
    output logic [CNTW-1:0]             retired
);
    import phase_seq_pkg::*;

    localparam int PW = $clog2(PHASES);
    localparam int SW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {S_RUN, S_HALTED, S_STEP} state_t;

    state_t            r_state, w_state_nxt;
    logic [SW-1:0]     r_stall;
    logic              r_mem_err;
    logic [CNTW-1:0]   r_retired;
    logic [PW-1:0]     w_phase;
    logic              w_halted, w_in_mem, w_wait, w_timeout, w_stall;
    logic              w_boundary, w_hold;

    assign w_halted   = (r_state == S_HALTED);
    assign w_in_mem   = !w_halted && (w_phase == MEM);
    assign w_wait     = w_in_mem && mem_access && !mem_ready;
    assign w_timeout  = w_wait && (r_stall == SW'(MEM_TIMEOUT));
    assign w_stall    = w_wait && !w_timeout;
    assign w_boundary = !w_halted && (w_phase == WB);
    // A halted core stays parked at FETCH.
    assign w_hold     = w_halted || w_stall;

    phase_ctr #(.N(PHASES), .W(PW)) u_ctr (
        .clk     (clk),
        .reset   (reset),
        .i_hold  (w_hold),
        .o_phase (w_phase)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_RUN;
            r_stall   <= '0;
            r_mem_err <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_stall <= w_stall ? r_stall + 1'b1 : '0;
            if (w_timeout)
                r_mem_err <= 1'b1;
            if (w_boundary)
                r_retired <= r_retired + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        phase       = w_phase;
        phase_en    = '0;
        mem_we_en   = 1'b0;
        wb_en       = 1'b0;
        halted      = w_halted;
        mem_err     = r_mem_err;
        retired     = r_retired;
        unique case (r_state)
            S_RUN:    if (w_boundary && halt_req) w_state_nxt = S_HALTED;
            S_HALTED: begin
                if (step_req)
                    w_state_nxt = S_STEP;
                else if (!halt_req)
                    w_state_nxt = S_RUN;
            end
            S_STEP:   if (w_boundary) w_state_nxt = S_HALTED;
            default:  w_state_nxt = S_RUN;
        endcase
        if (!w_halted)
            phase_en = {{(PHASES-1){1'b0}}, 1'b1} << w_phase;
        // Strobes are suppressed under reset so an abandoned instruction never commits.
        if (!reset) begin
            mem_we_en = w_in_mem && mem_access && mem_ready;
            wb_en     = w_boundary;
        end
    end
endmodule

// File: tb/tb_phase_seq.sv
// Scenario bench for phase_seq: per-cycle stimulus and expected outputs are
// queued together, then replayed and compared against the DUT.
module tb_phase_seq;
    logic        clk = 1'b0;
    logic        reset, halt_req, step_req, mem_access, mem_ready;
    logic [2:0]  phase;
    logic [4:0]  phase_en;
    logic        mem_we_en, wb_en, halted, mem_err;
    logic [15:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        rst, acc, rdy, hr, sr;
        logic [2:0]  ph;
        logic [4:0]  pe;
        logic        wb, we, hlt, err;
        logic [15:0] ret;
    } cyc_t;

    cyc_t q[$];

    phase_seq dut (
        .clk(clk), .reset(reset), .halt_req(halt_req), .step_req(step_req),
        .mem_access(mem_access), .mem_ready(mem_ready), .phase(phase),
        .phase_en(phase_en), .mem_we_en(mem_we_en), .wb_en(wb_en),
        .halted(halted), .mem_err(mem_err), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic void push(input logic rst, acc, rdy, hr, sr,
                                 input logic [2:0] ph, input logic wb, we, hlt, err,
                                 input logic [15:0] ret);
        cyc_t c;
        c.rst = rst; c.acc = acc; c.rdy = rdy; c.hr = hr; c.sr = sr;
        c.ph = ph; c.wb = wb; c.we = we; c.hlt = hlt; c.err = err; c.ret = ret;
        c.pe = hlt ? 5'd0 : 5'(1 << ph);
        q.push_back(c);
    endfunction

    task automatic apply_reset();
        reset = 1'b1; halt_req = 0; step_req = 0; mem_access = 0; mem_ready = 0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_tests++; if (phase !== 3'd0)      begin n_fail++; $display("FAIL reset_phase got %0d want 0", phase); end
        n_tests++; if (phase_en !== 5'b00001) begin n_fail++; $display("FAIL reset_phase_en got %b want 00001", phase_en); end
        n_tests++; if (halted !== 1'b0)     begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
        n_tests++; if (mem_we_en !== 1'b0)  begin n_fail++; $display("FAIL reset_we got %b want 0", mem_we_en); end
        n_tests++; if (wb_en !== 1'b0)      begin n_fail++; $display("FAIL reset_wb got %b want 0", wb_en); end
        n_tests++; if (mem_err !== 1'b0)    begin n_fail++; $display("FAIL reset_err got %b want 0", mem_err); end
        n_tests++; if (retired !== 16'd0)   begin n_fail++; $display("FAIL reset_retired got %0d want 0", retired); end
        @(posedge clk); #1;
    endtask

    task automatic test_no_stall();
        cyc_t cur;
        int   k = 0;
        logic [15:0] r = 0;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            push(0, 0, 0, 0, 0, 3'(i % 5), (i % 5) == 4, 0, 0, 0, r);
            if (i % 5 == 4) r++;
        end
        push(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 16'd2);
        while (q.size() > 0) begin
            cur = q.pop_front();
            reset = cur.rst; mem_access = cur.acc; mem_ready = cur.rdy;
            halt_req = cur.hr; step_req = cur.sr;
            @(negedge clk);
            n_tests++;
            if ({phase, phase_en, wb_en, mem_we_en, halted, mem_err, retired} !==
                {cur.ph, cur.pe, cur.wb, cur.we, cur.hlt, cur.err, cur.ret}) begin
                n_fail++;
                $display("FAIL no_stall cyc%0d got ph=%0d pe=%b wb=%b we=%b hlt=%b err=%b ret=%0d want ph=%0d pe=%b wb=%b we=%b hlt=%b err=%b ret=%0d",
                         k, phase, phase_en, wb_en, mem_we_en, halted, mem_err, retired,
                         cur.ph, cur.pe, cur.wb, cur.we, cur.hlt, cur.err, cur.ret);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        cyc_t cur;
        int   k = 0;
        apply_reset();
        for (int p = 0; p < 3; p++) push(0, 1, 0, 0, 0, 3'(p), 0, 0, 0, 0, 0);
        for (int s = 0; s < 3; s++) push(0, 1, 0, 0, 0, 3'd3, 0, 0, 0, 0, 0);
        push(0, 1, 1, 0, 0, 3'd3, 0, 1, 0, 0, 0);
        push(0, 0, 0, 0, 0, 3'd4, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1);
        while (q.size() > 0) begin
            cur = q.pop_front();
            reset = cur.rst; mem_access = cur.acc; mem_ready = cur.rdy;
            halt_req = cur.hr; step_req = cur.sr;
            @(negedge clk);
            n_tests++;
            if ({phase, phase_en, wb_en, mem_we_en, halted, mem_err, retired} !==
                {cur.ph, cur.pe, cur.wb, cur.we, cur.hlt, cur.err, cur.ret}) begin
                n_fail++;
                $display("FAIL stall cyc%0d got ph=%0d pe=%b wb=%b we=%b hlt=%b err=%b ret=%0d want ph=%0d pe=%b wb=%b we=%b hlt=%b err=%b ret=%0d",
                         k, phase, phase_en, wb_en, mem_we_en, halted, mem_err, retired,
                         cur.ph, cur.pe, cur.wb, cur.we, cur.hlt, cur.err, cur.ret);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        cyc_t cur;
        int   k = 0;
        apply_reset();
        for (int p = 0; p < 3; p++) push(0, 1, 0, 0, 0, 3'(p), 0, 0, 0, 0, 0);
        for (int s = 0; s < 16; s++) push(0, 1, 0, 0, 0, 3'd3, 0, 0, 0, 0, 0);
        push(0, 1, 0, 0, 0, 3'd4, 1, 0, 0, 1, 0);
        for (int p = 0; p < 5; p++) push(0, 0, 0, 0, 0, 3'(p), p == 4, 0, 0, 1, 1);
        push(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 2);
        while (q.size() > 0) begin
            cur = q.pop_front();
            reset = cur.rst; mem_access = cur.acc; mem_ready = cur.rdy;
            halt_req = cur.hr; step_req = cur.sr;
            @(negedge clk);
            n_tests++;
            if ({phase, phase_en, wb_en, mem_we_en, halted, mem_err, retired} !==
                {cur.ph, cur.pe, cur.wb, cur.we, cur.hlt, cur.err, cur.ret}) begin
                n_fail++;
                $display("FAIL timeout cyc%0d got ph=%0d pe=%b wb=%b we=%b hlt=%b err=%b ret=%0d want ph=%0d pe=%b wb=%b we=%b hlt=%b err=%b ret=%0d",
                         k, phase, phase_en, wb_en, mem_we_en, halted, mem_err, retired,
                         cur.ph, cur.pe, cur.wb, cur.we, cur.hlt, cur.err, cur.ret);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt_step();
        cyc_t cur;
        int   k = 0;
        apply_reset();
        push(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0, 0);
        push(0, 0, 0, 1, 0, 3'd2, 0, 0, 0, 0, 0);
        push(0, 0, 0, 1, 0, 3'd3, 0, 0, 0, 0, 0);
        push(0, 0, 0, 1, 0, 3'd4, 1, 0, 0, 0, 0);
        push(0, 0, 0, 1, 0, 3'd0, 0, 0, 1, 0, 1);
        push(0, 0, 0, 1, 0, 3'd0, 0, 0, 1, 0, 1);
        for (int s = 0; s < 3; s++) begin
            push(0, 0, 0, 1, 1, 3'd0, 0, 0, 1, 0, 16'(1 + s));
            for (int p = 0; p < 5; p++)
                push(0, 0, 0, 1, 0, 3'(p), p == 4, 0, 0, 0, 16'(1 + s));
        end
        push(0, 0, 0, 1, 0, 3'd0, 0, 0, 1, 0, 4);
        push(0, 0, 0, 0, 0, 3'd0, 0, 0, 1, 0, 4);
        push(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 4);
        push(0, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0, 4);
        while (q.size() > 0) begin
            cur = q.pop_front();
            reset = cur.rst; mem_access = cur.acc; mem_ready = cur.rdy;
            halt_req = cur.hr; step_req = cur.sr;
            @(negedge clk);
            n_tests++;
            if ({phase, phase_en, wb_en, mem_we_en, halted, mem_err, retired} !==
                {cur.ph, cur.pe, cur.wb, cur.we, cur.hlt, cur.err, cur.ret}) begin
                n_fail++;
                $display("FAIL halt_step cyc%0d got ph=%0d pe=%b wb=%b we=%b hlt=%b err=%b ret=%0d want ph=%0d pe=%b wb=%b we=%b hlt=%b err=%b ret=%0d",
                         k, phase, phase_en, wb_en, mem_we_en, halted, mem_err, retired,
                         cur.ph, cur.pe, cur.wb, cur.we, cur.hlt, cur.err, cur.ret);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_cancel();
        cyc_t cur;
        int   k = 0;
        apply_reset();
        push(0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 1, 0, 3'd1, 0, 0, 0, 0, 0);
        push(0, 0, 0, 1, 0, 3'd2, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 3'd3, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 3'd4, 1, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1);
        push(0, 0, 0, 0, 1, 3'd1, 0, 0, 0, 0, 1);
        push(0, 0, 0, 0, 0, 3'd2, 0, 0, 0, 0, 1);
        push(0, 0, 0, 0, 0, 3'd3, 0, 0, 0, 0, 1);
        push(0, 0, 0, 0, 1, 3'd4, 1, 0, 0, 0, 1);
        push(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 2);
        while (q.size() > 0) begin
            cur = q.pop_front();
            reset = cur.rst; mem_access = cur.acc; mem_ready = cur.rdy;
            halt_req = cur.hr; step_req = cur.sr;
            @(negedge clk);
            n_tests++;
            if ({phase, phase_en, wb_en, mem_we_en, halted, mem_err, retired} !==
                {cur.ph, cur.pe, cur.wb, cur.we, cur.hlt, cur.err, cur.ret}) begin
                n_fail++;
                $display("FAIL cancel cyc%0d got ph=%0d pe=%b wb=%b we=%b hlt=%b err=%b ret=%0d want ph=%0d pe=%b wb=%b we=%b hlt=%b err=%b ret=%0d",
                         k, phase, phase_en, wb_en, mem_we_en, halted, mem_err, retired,
                         cur.ph, cur.pe, cur.wb, cur.we, cur.hlt, cur.err, cur.ret);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_stall();
        cyc_t cur;
        int   k = 0;
        apply_reset();
        for (int p = 0; p < 3; p++) push(0, 1, 0, 0, 0, 3'(p), 0, 0, 0, 0, 0);
        for (int s = 0; s < 16; s++) push(0, 1, 0, 0, 0, 3'd3, 0, 0, 0, 0, 0);
        push(0, 1, 0, 0, 0, 3'd4, 1, 0, 0, 1, 0);
        for (int p = 0; p < 3; p++) push(0, 1, 0, 0, 0, 3'(p), 0, 0, 0, 1, 1);
        for (int s = 0; s < 3; s++) push(0, 1, 0, 0, 0, 3'd3, 0, 0, 0, 1, 1);
        push(1, 1, 1, 0, 0, 3'd3, 0, 0, 0, 1, 1);
        for (int p = 0; p < 5; p++) push(0, 0, 0, 0, 0, 3'(p), p == 4, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 1);
        while (q.size() > 0) begin
            cur = q.pop_front();
            reset = cur.rst; mem_access = cur.acc; mem_ready = cur.rdy;
            halt_req = cur.hr; step_req = cur.sr;
            @(negedge clk);
            n_tests++;
            if ({phase, phase_en, wb_en, mem_we_en, halted, mem_err, retired} !==
                {cur.ph, cur.pe, cur.wb, cur.we, cur.hlt, cur.err, cur.ret}) begin
                n_fail++;
                $display("FAIL reset_stall cyc%0d got ph=%0d pe=%b wb=%b we=%b hlt=%b err=%b ret=%0d want ph=%0d pe=%b wb=%b we=%b hlt=%b err=%b ret=%0d",
                         k, phase, phase_en, wb_en, mem_we_en, halted, mem_err, retired,
                         cur.ph, cur.pe, cur.wb, cur.we, cur.hlt, cur.err, cur.ret);
            end
            k++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_no_stall();
        test_stall();
        test_timeout();
        test_halt_step();
        test_cancel();
        test_reset_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
